sa_output_collector: RTL and testbench

Receiver for the bottom edge of the output-stationary systolic array. It accepts the skewed per-column `valid_down`/`data_down` stream, deskews it into whole output rows, and writes each row to the output (down) SRAM bank at consecutive addresses from a programmed base. When idle, it also muxes a host read port onto the same SRAM bank, and it reports busy, done and protocol errors back to the top-level sequencer.

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_deskew_delay.sv | 43 ++++
 rtl/sa_output_collector.sv | 134 +++++++++++++
 tb/tb_sa_output_collector.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array output path: FSM encoding,
// SRAM strobe polarities and the default geometry used by the array controller.
package sa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic READ_ENABLE  = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;

  localparam int DEF_NUM_COL              = 8;
  localparam int DEF_ACCU_DATA_WIDTH      = 32;
  localparam int DEF_LOG2_SRAM_BANK_DEPTH = 10;

  // Column c lags column 0 by c cycles, so it must wait out the remainder.
  function automatic int deskew_depth(input int col, input int num_col, input int skew_en);
    return (skew_en != 0) ? (num_col - 1 - col) : 0;
  endfunction

endpackage

// File: rtl/sa_deskew_delay.sv
// Fixed-length shift register of {valid, data}; DEPTH=0 degenerates to a wire.
module sa_deskew_delay #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused_clk;
      assign w_unused_clk = clk ^ rst_n;
      assign o_vld = i_vld;
      assign o_dat = i_dat;
    end else begin : g_shift
      logic [DEPTH-1:0]            r_vld;
      logic [DEPTH-1:0][WIDTH-1:0] r_dat;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          r_dat <= '0;
        end else begin
          r_vld[0] <= i_vld;
          r_dat[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_dat[i] <= r_dat[i-1];
          end
        end
      end

      assign o_vld = r_vld[DEPTH-1];
      assign o_dat = r_dat[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_output_collector.sv
// Deskews the array's bottom-edge stream into whole rows and writes them to the
// output SRAM bank from a programmed base; shares the bank with a host read port when idle.
module sa_output_collector
  import sa_pkg::*;
#(
  parameter int NUM_COL              = DEF_NUM_COL,
  parameter int ACCU_DATA_WIDTH      = DEF_ACCU_DATA_WIDTH,
  parameter int LOG2_SRAM_BANK_DEPTH = DEF_LOG2_SRAM_BANK_DEPTH,
  parameter int SKEW_EN              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_base_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH:0]        i_num_rows,
  input  logic [NUM_COL-1:0]                   i_valid_down,
  input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   i_data_down,
  input  logic                                 i_host_rd_en,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]      i_host_rd_addr,
  output logic                                 o_sram_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]      o_sram_addr,
  output logic [NUM_COL*ACCU_DATA_WIDTH-1:0]   o_sram_wr_data,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int DW = NUM_COL * ACCU_DATA_WIDTH;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_base, r_addr;
  logic [AW:0]   r_num_rows, r_cnt;
  logic [DW-1:0] r_data;
  logic          r_wr_en, r_err;

  logic [NUM_COL-1:0] w_vin, w_dvld;
  logic [DW-1:0]      w_ddat;
  logic               w_idle, w_start, w_room, w_full, w_part, w_accept, w_err_set;

  // Columns seen while idle are dropped before they can reach the delay lines.
  assign w_idle = (r_state == ST_IDLE);
  assign w_vin  = i_valid_down & {NUM_COL{!w_idle}};

  generate
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      sa_deskew_delay #(
        .DEPTH(deskew_depth(c, NUM_COL, SKEW_EN)),
        .WIDTH(ACCU_DATA_WIDTH)
      ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .i_vld(w_vin[c]),
        .i_dat(i_data_down[c*ACCU_DATA_WIDTH +: ACCU_DATA_WIDTH]),
        .o_vld(w_dvld[c]),
        .o_dat(w_ddat[c*ACCU_DATA_WIDTH +: ACCU_DATA_WIDTH])
      );
    end
  endgenerate

  assign w_start   = i_start && w_idle;
  assign w_room    = (r_cnt != r_num_rows);
  assign w_full    = &w_dvld;
  assign w_part    = |w_dvld && !w_full;
  assign w_accept  = (r_state == ST_COLLECT) && w_full && w_room;
  assign w_err_set = (w_idle && |i_valid_down) ||
                     (!w_idle && (w_part || (w_full && !w_room)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_state_nxt = ST_COLLECT;
      ST_COLLECT: if (!w_room) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_sram_wr_en = READ_ENABLE;
    o_sram_addr  = r_addr;
    case (r_state)
      ST_IDLE: if (i_host_rd_en) o_sram_addr = i_host_rd_addr;
      ST_COLLECT: begin
        o_busy       = 1'b1;
        o_sram_wr_en = r_wr_en;
      end
      ST_DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        o_sram_wr_en = r_wr_en;
      end
      default: ;
    endcase
  end

  // Row counter compares at AW+1 bits; the address adder wraps at the bank depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_num_rows <= '0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wr_en    <= READ_ENABLE;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= w_accept ? WRITE_ENABLE : READ_ENABLE;
      if (w_start) begin
        r_base     <= i_base_addr;
        r_num_rows <= i_num_rows;
        r_cnt      <= '0;
      end
      if (w_accept) begin
        r_addr <= r_base + r_cnt[AW-1:0];
        r_data <= w_ddat;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_err_set)    r_err <= 1'b1;
      else if (w_start) r_err <= 1'b0;
    end
  end

  assign o_sram_wr_data = r_data;
  assign o_err          = r_err;

endmodule

// File: tb/tb_sa_output_collector.sv
// Randomized bench for sa_output_collector: skewed row schedules checked cycle by cycle
// against a row-level model of addresses, data, busy/done timing and the error flag.
module tb_sa_output_collector;

  localparam int NC = 4, WW = 32, AW = 10, DW = NC * WW, MAXC = 64, MAXR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, i_start, i_host_rd_en;
  logic [AW-1:0] i_base_addr, i_host_rd_addr;
  logic [AW:0]   i_num_rows;
  logic [NC-1:0] i_valid_down;
  logic [DW-1:0] i_data_down;
  logic          o_sram_wr_en, o_busy, o_done, o_err;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wr_data;

  sa_output_collector #(
    .NUM_COL(NC), .ACCU_DATA_WIDTH(WW), .LOG2_SRAM_BANK_DEPTH(AW), .SKEW_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_rows(i_num_rows), .i_valid_down(i_valid_down), .i_data_down(i_data_down),
    .i_host_rd_en(i_host_rd_en), .i_host_rd_addr(i_host_rd_addr),
    .o_sram_wr_en(o_sram_wr_en), .o_sram_addr(o_sram_addr), .o_sram_wr_data(o_sram_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int checks = 0, failures = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_dat;

  task automatic idle_inputs();
    i_start = 1'b0; i_base_addr = '0; i_num_rows = '0;
    i_valid_down = '0; i_data_down = '0; i_host_rd_en = 1'b0; i_host_rd_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); i_host_rd_addr = AW'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (o_sram_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", o_sram_wr_en); end
    checks++; if (o_sram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", o_sram_addr); end
    checks++; if (o_sram_wr_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", o_sram_wr_data); end
    checks++; if ({o_busy, o_done, o_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {o_busy, o_done, o_err}); end
    rst_n = 1'b1; last_addr = '0; last_dat = '0;
    step();
  endtask

  // Model: rows launch at offsets st[r]; column c of a row is driven c cycles later.
  // Complete rows are written in order at base+k (wrapped) NC cycles after launch,
  // until num_rows are written; dropped or surplus rows raise the error flag.
  task automatic run_job(input logic [AW-1:0] base, input int nrows, input int nsend,
                         input int drop_row, input int drop_col, input bit patt,
                         input int gapmax, input int busy_start_at);
    logic [NC-1:0] sv [MAXC];
    logic [DW-1:0] sd [MAXC];
    bit            ew [MAXC];
    logic [AW-1:0] ea [MAXC];
    logic [DW-1:0] ed [MAXC];
    logic [DW-1:0] rowdat [MAXR];
    int st [MAXR];
    int s, k, done_idx, len;
    bit exp_err, exp_busy;
    logic [WW-1:0] word;
    for (int i = 0; i < MAXC; i++) begin sv[i] = '0; sd[i] = '0; ew[i] = 0; ea[i] = '0; ed[i] = '0; end
    s = 0;
    for (int r = 0; r < nsend; r++) begin
      st[r] = s; rowdat[r] = '0;
      for (int c = 0; c < NC; c++) begin
        word = patt ? WW'(r * 16 + c) : WW'($urandom);
        if (!(r == drop_row && c == drop_col)) sv[s+c][c] = 1'b1;
        sd[s+c][c*WW +: WW] = word;
        rowdat[r][c*WW +: WW] = word;
      end
      s += 1 + $urandom_range(0, gapmax);
    end
    k = 0; exp_err = 0; done_idx = (nrows == 0) ? 1 : -1;
    for (int r = 0; r < nsend; r++) begin
      if (r == drop_row) exp_err = 1;
      else if (k < nrows) begin
        ew[st[r]+NC] = 1; ea[st[r]+NC] = base + AW'(k); ed[st[r]+NC] = rowdat[r];
        k++;
        if (k == nrows) done_idx = st[r] + NC + 1;
      end else exp_err = 1;
    end
    len = s + NC + 3;
    if (done_idx + 3 > len) len = done_idx + 3;

    i_start = 1'b1; i_base_addr = base; i_num_rows = (AW+1)'(nrows);
    step();
    i_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      i_valid_down = sv[i]; i_data_down = sd[i];
      i_host_rd_en = 1'($urandom); i_host_rd_addr = AW'($urandom);
      if (i == busy_start_at) begin
        i_start = 1'b1; i_base_addr = AW'($urandom); i_num_rows = (AW+1)'($urandom_range(1, 7));
      end else i_start = 1'b0;
      @(negedge clk);
      exp_busy = (i <= done_idx);
      if (i == 0) begin
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL job_err_cleared cyc=%0d got=%b exp=0", i, o_err); end
      end
      checks++; if (o_busy !== exp_busy) begin failures++; $display("FAIL job_busy cyc=%0d got=%b exp=%b", i, o_busy, exp_busy); end
      checks++; if (o_done !== (i == done_idx)) begin failures++; $display("FAIL job_done cyc=%0d got=%b exp=%b", i, o_done, (i == done_idx)); end
      checks++; if (o_sram_wr_en !== ew[i]) begin failures++; $display("FAIL job_wr_en cyc=%0d got=%b exp=%b", i, o_sram_wr_en, ew[i]); end
      if (ew[i]) begin last_addr = ea[i]; last_dat = ed[i]; end
      if (exp_busy) begin
        checks++; if (o_sram_addr !== last_addr) begin failures++; $display("FAIL job_addr cyc=%0d got=%h exp=%h", i, o_sram_addr, last_addr); end
      end else if (i_host_rd_en) begin
        checks++; if (o_sram_addr !== i_host_rd_addr) begin failures++; $display("FAIL job_host_addr cyc=%0d got=%h exp=%h", i, o_sram_addr, i_host_rd_addr); end
      end
      checks++; if (o_sram_wr_data !== last_dat) begin failures++; $display("FAIL job_data cyc=%0d got=%h exp=%h", i, o_sram_wr_data, last_dat); end
      step();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (o_err !== exp_err) begin failures++; $display("FAIL job_err_final got=%b exp=%b", o_err, exp_err); end
    step();
  endtask

  task automatic test_basic();      run_job(10'h010, 3, 3, -1, 0, 1, 1, -1); endtask
  task automatic test_wrap();       run_job(10'h3FE, 3, 3, -1, 0, 0, 2, -1); endtask
  task automatic test_misalign();   run_job(10'h020, 3, 4, 1, 2, 0, 1, -1); endtask
  task automatic test_extra_rows(); run_job(AW'($urandom), 2, 4, -1, 0, 0, 2, -1); endtask
  task automatic test_back_to_back(); run_job(AW'($urandom), 6, 6, -1, 0, 0, 0, 2); endtask

  task automatic test_zero_rows();
    run_job(AW'($urandom), 0, 0, -1, 0, 0, 0, -1);
    i_valid_down = 4'b0100; i_data_down = DW'($urandom);
    step();
    idle_inputs();
    @(negedge clk);
    checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL idle_valid_err got=%b exp=1", o_err); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL idle_valid_busy got=%b exp=0", o_busy); end
    step();
  endtask

  task automatic test_host_read();
    i_host_rd_en = 1'b1; i_host_rd_addr = 10'h011;
    @(negedge clk);
    checks++; if (o_sram_addr !== 10'h011) begin failures++; $display("FAIL host_addr got=%h exp=011", o_sram_addr); end
    checks++; if (o_sram_wr_en !== 1'b0) begin failures++; $display("FAIL host_wr_en got=%b exp=0", o_sram_wr_en); end
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    i_start = 1'b1; i_base_addr = 10'h100; i_num_rows = 11'd2;
    step();
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid_down = NC'((1 << (i + 1)) - 1); i_data_down = {4{32'($urandom)}};
      step();
    end
    #2 rst_n = 1'b0; idle_inputs(); i_host_rd_addr = AW'($urandom);
    #1;
    checks++; if ({o_busy, o_done, o_err, o_sram_wr_en} !== 4'b0000) begin failures++; $display("FAIL midreset_flags got=%b exp=0000", {o_busy, o_done, o_err, o_sram_wr_en}); end
    checks++; if (o_sram_addr !== '0) begin failures++; $display("FAIL midreset_addr got=%h exp=0", o_sram_addr); end
    checks++; if (o_sram_wr_data !== '0) begin failures++; $display("FAIL midreset_data got=%h exp=0", o_sram_wr_data); end
    step(); step();
    rst_n = 1'b1; last_addr = '0; last_dat = '0;
    step();
    run_job(10'h200, 3, 3, -1, 0, 0, 1, -1);
  endtask

  task automatic test_random_jobs();
    int n;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 5);
      run_job(AW'($urandom), n, n, -1, 0, 0, 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_misalign();
    test_zero_rows();
    test_host_read();
    test_back_to_back();
    test_extra_rows();
    test_reset_mid();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
